// File: rtl/racing_pkg.sv
// Shared constants for the racing-game paddle interface: bus widths,
// button index map and the per-frame throttle command.
package racing_pkg;

  localparam int LINE_W  = 10;
  localparam int THR_W   = 9;
  localparam int NUM_BTN = 4;

  localparam int BTN_LEFT  = 0;
  localparam int BTN_RIGHT = 1;
  localparam int BTN_ACCEL = 2;
  localparam int BTN_BRAKE = 3;

  typedef enum logic [1:0] {
    THR_HOLD,
    THR_UP,
    THR_DOWN
  } thr_cmd_e;

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchronizer followed by a counting debouncer: a new level is
// accepted only after it has been seen for DEBOUNCE_CYCLES consecutive cycles.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int DB_W            = 18
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic level_o
);

  localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]      sync_q;
  logic            level_q, level_d;
  logic [DB_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  // Any return to the accepted level restarts the count, so short bounces vanish.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/paddle_transmitter.sv
// Turns debounced board buttons into the game's paddle signals: registered
// steering bits and a per-frame, line-timed active-low throttle waveform.
module paddle_transmitter
  import racing_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int DB_W            = 18,
  parameter int THR_INIT        = 240,
  parameter int THR_MAX         = 479,
  parameter int THR_STEP        = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hsync,
  input  logic       vsync,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_accel,
  input  logic       btn_brake,
  output logic       hpaddle_left,
  output logic       hpaddle_right,
  output logic       vpaddle,
  output logic [8:0] throttle
);

  localparam logic [LINE_W-1:0] STEP_EXT = LINE_W'(THR_STEP);
  localparam logic [LINE_W-1:0] MAX_EXT  = LINE_W'(THR_MAX);
  localparam logic [THR_W-1:0]  STEP_THR = THR_W'(THR_STEP);
  localparam logic [THR_W-1:0]  MAX_THR  = THR_W'(THR_MAX);

  logic [NUM_BTN-1:0] btn_raw, btn_db;

  assign btn_raw[BTN_LEFT]  = btn_left;
  assign btn_raw[BTN_RIGHT] = btn_right;
  assign btn_raw[BTN_ACCEL] = btn_accel;
  assign btn_raw[BTN_BRAKE] = btn_brake;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_db
    button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .DB_W           (DB_W)
    ) u_db (
      .clk    (clk),
      .reset  (reset),
      .btn_i  (btn_raw[g]),
      .level_o(btn_db[g])
    );
  end

  logic              hsync_prev_q, vsync_prev_q;
  logic              hl_q, hl_d, hr_q, hr_d;
  logic [THR_W-1:0]  thr_q, thr_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic              vpaddle_q, vpaddle_d;

  logic              hsync_rise, vsync_rise;
  logic [LINE_W-1:0] thr_ext, thr_up;
  thr_cmd_e          cmd;

  always_ff @(posedge clk) begin
    if (reset) begin
      hsync_prev_q <= 1'b0;
      vsync_prev_q <= 1'b0;
      hl_q         <= 1'b0;
      hr_q         <= 1'b0;
      thr_q        <= THR_W'(THR_INIT);
      line_q       <= '0;
      vpaddle_q    <= 1'b1;
    end else begin
      hsync_prev_q <= hsync;
      vsync_prev_q <= vsync;
      hl_q         <= hl_d;
      hr_q         <= hr_d;
      thr_q        <= thr_d;
      line_q       <= line_d;
      vpaddle_q    <= vpaddle_d;
    end
  end

  always_comb begin
    hsync_rise = hsync & ~hsync_prev_q;
    vsync_rise = vsync & ~vsync_prev_q;

    hl_d = btn_db[BTN_LEFT] & ~btn_db[BTN_RIGHT];
    hr_d = btn_db[BTN_RIGHT] & ~btn_db[BTN_LEFT];

    cmd = THR_HOLD;
    if (btn_db[BTN_ACCEL] && !btn_db[BTN_BRAKE]) begin
      cmd = THR_UP;
    end else if (btn_db[BTN_BRAKE] && !btn_db[BTN_ACCEL]) begin
      cmd = THR_DOWN;
    end

    // Extended by one bit so the upward step can be compared before it wraps.
    thr_ext = {1'b0, thr_q};
    thr_up  = thr_ext + STEP_EXT;
    thr_d   = thr_q;
    if (vsync_rise) begin
      case (cmd)
        THR_UP:   thr_d = (thr_up > MAX_EXT) ? MAX_THR : thr_up[THR_W-1:0];
        THR_DOWN: thr_d = (thr_ext < STEP_EXT) ? '0 : (thr_q - STEP_THR);
        default:  thr_d = thr_q;
      endcase
    end

    // A frame start wins over a coincident line start.
    line_d = line_q;
    if (vsync_rise) begin
      line_d = '0;
    end else if (hsync_rise && (line_q != '1)) begin
      line_d = line_q + 1'b1;
    end

    vpaddle_d = ~(line_q <= thr_ext);
  end

  assign hpaddle_left  = hl_q;
  assign hpaddle_right = hr_q;
  assign vpaddle       = vpaddle_q;
  assign throttle      = thr_q;

endmodule

// File: tb/tb_paddle_transmitter.sv
// Scoreboard bench for paddle_transmitter: stimulus queues timed expectations
// from a behavioural model, a negedge monitor pops and compares them.
module tb_paddle_transmitter;

  localparam int DB   = 4;
  localparam int STEP = 4;
  localparam int INIT = 240;
  localparam int MAXT = 479;

  logic       clk = 1'b0;
  logic       reset;
  logic       hsync, vsync;
  logic       btn_left, btn_right, btn_accel, btn_brake;
  logic       hpaddle_left, hpaddle_right, vpaddle;
  logic [8:0] throttle;

  paddle_transmitter #(
    .DEBOUNCE_CYCLES(DB),
    .DB_W           (3),
    .THR_INIT       (INIT),
    .THR_MAX        (MAXT),
    .THR_STEP       (STEP)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .hsync        (hsync),
    .vsync        (vsync),
    .btn_left     (btn_left),
    .btn_right    (btn_right),
    .btn_accel    (btn_accel),
    .btn_brake    (btn_brake),
    .hpaddle_left (hpaddle_left),
    .hpaddle_right(hpaddle_right),
    .vpaddle      (vpaddle),
    .throttle     (throttle)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int    at;
    string name;
    bit    chkS;
    bit    hl;
    bit    hr;
    bit    chkT;
    int    thr;
    bit    chkV;
    bit    vp;
  } expT;

  expT sb[$];
  int  errors = 0;
  int  checks = 0;

  // Model state: accepted button levels, throttle and current line.
  bit mL = 0, mR = 0;
  int mThr = INIT;
  int mLine = 0;

  function automatic int nextThr(input int t, input bit a, input bit b);
    if (a && !b) return (t + STEP > MAXT) ? MAXT : t + STEP;
    if (b && !a) return (t < STEP) ? 0 : t - STEP;
    return t;
  endfunction

  task automatic pushExp(input int at, input string name, input bit chkS, input bit hl,
                         input bit hr, input bit chkT, input int thr, input bit chkV,
                         input bit vp);
    expT e;
    int  i;
    e.at = at; e.name = name; e.chkS = chkS; e.hl = hl; e.hr = hr;
    e.chkT = chkT; e.thr = thr; e.chkV = chkV; e.vp = vp;
    i = 0;
    while (i < sb.size() && sb[i].at <= at) i++;
    sb.insert(i, e);
  endtask

  task automatic checkOutput(input expT e);
    if (e.at != cyc) begin
      checks++; errors++;
      $display("[TB] FAIL %s: checked at cycle %0d, due at %0d", e.name, cyc, e.at);
      return;
    end
    if (e.chkS) begin
      checks++;
      if (hpaddle_left !== e.hl || hpaddle_right !== e.hr) begin
        errors++;
        $display("[TB] FAIL %s steer @%0d: got L=%b R=%b want L=%b R=%b", e.name, cyc,
                 hpaddle_left, hpaddle_right, e.hl, e.hr);
      end
    end
    if (e.chkT) begin
      checks++;
      if (int'(throttle) != e.thr || $isunknown(throttle)) begin
        errors++;
        $display("[TB] FAIL %s throttle @%0d: got %0d want %0d", e.name, cyc, throttle, e.thr);
      end
    end
    if (e.chkV) begin
      checks++;
      if (vpaddle !== e.vp) begin
        errors++;
        $display("[TB] FAIL %s vpaddle @%0d: got %b want %b", e.name, cyc, vpaddle, e.vp);
      end
    end
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].at <= cyc) checkOutput(sb.pop_front());
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Steering step: both buttons change together, so their accepted levels
  // move on the same edge and steering follows one edge later.
  task automatic applyStimulus(input bit l, input bit r, input string name);
    int k;
    k = cyc;
    btn_left  = l;
    btn_right = r;
    pushExp(k + DB + 2, {name, "_pre"}, 1, mL && !mR, mR && !mL, 1, mThr, 0, 0);
    pushExp(k + DB + 3, name, 1, l && !r, r && !l, 1, mThr, 0, 0);
    mL = l; mR = r;
    tick(10);
  endtask

  // One frame start with the given throttle buttons settled beforehand.
  task automatic frameStep(input bit a, input bit b, input string name);
    int k;
    btn_accel = a;
    btn_brake = b;
    pushExp(cyc + 9, {name, "_old"}, 0, 0, 0, 1, mThr, 0, 0);
    tick(9);
    k = cyc;
    vsync = 1'b1;
    mThr  = nextThr(mThr, a, b);
    mLine = 0;
    pushExp(k + 1, name, 0, 0, 0, 1, mThr, 0, 0);
    pushExp(k + 2, {name, "_vp"}, 0, 0, 0, 1, mThr, 1, mLine > mThr);
    tick(1);
    vsync = 1'b0;
    tick(2);
  endtask

  task automatic lineFrame(input bit a, input bit b, input int nLines);
    int k;
    frameStep(a, b, "line_frame");
    for (int j = 0; j < nLines; j++) begin
      k = cyc;
      hsync = 1'b1;
      mLine = (mLine < 1023) ? mLine + 1 : 1023;
      pushExp(k + 2, $sformatf("line%0d_thr%0d", mLine, mThr), 0, 0, 0, 1, mThr, 1,
              mLine > mThr);
      tick(1);
      hsync = 1'b0;
      tick(1);
    end
  endtask

  initial begin
    #500000;
    errors++;
    $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int k;
    reset = 1'b1; hsync = 1'b0; vsync = 1'b0;
    btn_left = 1'b0; btn_right = 1'b0; btn_accel = 1'b0; btn_brake = 1'b0;
    pushExp(3, "reset", 1, 0, 0, 1, INIT, 1, 1);
    tick(3);
    reset = 1'b0;
    tick(2);

    $display("[TB] steering");
    applyStimulus(1, 0, "left_on");
    applyStimulus(0, 0, "left_off");
    k = cyc;
    btn_left = 1'b1;
    pushExp(k + 7, "pulse3_a", 1, 0, 0, 1, mThr, 0, 0);
    pushExp(k + 10, "pulse3_b", 1, 0, 0, 1, mThr, 0, 0);
    tick(3);
    btn_left = 1'b0;
    tick(12);
    applyStimulus(1, 1, "both");
    applyStimulus(0, 1, "right_only");
    applyStimulus(0, 0, "release");
    repeat (8) applyStimulus(1'($urandom), 1'($urandom), "rand_steer");
    applyStimulus(0, 0, "release2");

    $display("[TB] throttle");
    repeat (3) frameStep(1, 0, "accel");
    while (mThr < MAXT) frameStep(1, 0, "accel_run");
    repeat (2) frameStep(1, 0, "accel_sat");
    repeat (2) frameStep(1, 1, "both_hold");
    while (mThr > 0) frameStep(0, 1, "brake_run");
    repeat (2) frameStep(0, 1, "brake_sat");
    repeat (20) frameStep(1'($urandom), 1'($urandom), "rand_thr");
    while (mThr > 0) frameStep(0, 1, "brake_run2");

    $display("[TB] line timing");
    frameStep(1, 0, "to4");
    frameStep(1, 0, "to8");
    lineFrame(0, 0, 12);
    lineFrame(1, 0, 15);
    repeat (4) lineFrame(1'($urandom), 1'($urandom), $urandom_range(3, 20));

    $display("[TB] coincident syncs");
    while (mThr > 0) frameStep(0, 1, "brake_run3");
    lineFrame(0, 0, 3);
    k = cyc;
    vsync = 1'b1; hsync = 1'b1;
    mLine = 0;
    pushExp(k + 2, "vs_hs_same", 0, 0, 0, 1, mThr, 1, 0);
    tick(1);
    vsync = 1'b0; hsync = 1'b0;
    tick(1);
    k = cyc;
    hsync = 1'b1;
    mLine = 1;
    pushExp(k + 2, "line_after_same", 0, 0, 0, 1, mThr, 1, 1);
    tick(1);
    hsync = 1'b0;
    tick(2);

    $display("[TB] reset mid-frame");
    applyStimulus(1, 0, "pre_reset_left");
    lineFrame(1, 0, 6);
    k = cyc;
    reset = 1'b1;
    pushExp(k + 1, "mid_reset", 1, 0, 0, 1, INIT, 1, 1);
    tick(1);
    reset = 1'b0;
    btn_left = 1'b0; btn_accel = 1'b0;
    mL = 0; mR = 0; mThr = INIT; mLine = 0;
    pushExp(k + 2, "post_reset", 1, 0, 0, 1, INIT, 1, 0);
    pushExp(k + 12, "post_reset_hold", 1, 0, 0, 1, INIT, 1, 0);
    tick(15);

    while (sb.size() > 0) begin
      expT e;
      e = sb.pop_front();
      checks++; errors++;
      $display("[TB] FAIL %s: expectation for cycle %0d never checked", e.name, e.at);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
